// File: rtl/lsu.sv
// Load/store unit between the execute stage and the data port of ram.
// Takes one request at a time over a valid/ready handshake. It checks funct3
// and alignment, drives ram's d_addr/d_in/d_size/w_en for one ISSUE cycle,
// and returns a one-cycle response. Load data is sign- or zero-extended.
//
// Ports:
//   clk, reset              sole clock; synchronous active-high reset
//   req_valid/req_ready     request handshake (accepted only in IDLE)
//   req_we, req_funct3      store/load select and RISC-V funct3
//   req_addr, req_wdata     byte address and right-justified store data
//   resp_valid/rdata/err    one-cycle response strobe, load data, error flag
//   d_addr/d_in/d_size/w_en ram data port, nonzero only during ISSUE
//   d_out                   ram read data, valid the cycle after d_addr
module lsu #(
  parameter int unsigned ADDR_W = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] d_addr,
  output logic [31:0]       d_in,
  output logic [1:0]        d_size,
  output logic              w_en,
  input  logic [31:0]       d_out
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              req_illegal;
  logic              req_misalign;
  logic              issue;
  logic [31:0]       wdata_masked;

  // Decode of the incoming request; only consulted in IDLE.
  always_comb begin
    if (req_we) begin
      req_illegal = (req_funct3 >= 3'd3);
    end else begin
      req_illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
    end
    req_misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  end

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          we_d     = req_we;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          rdata_d  = 32'd0;
          if (req_illegal || req_misalign) begin
            err_d   = 1'b1;
            state_d = StResp;
          end else begin
            err_d   = 1'b0;
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        state_d = we_q ? StResp : StWait;
      end
      StWait: begin
        unique case (funct3_q)
          3'b000:  rdata_d = {{24{d_out[7]}}, d_out[7:0]};
          3'b001:  rdata_d = {{16{d_out[15]}}, d_out[15:0]};
          3'b010:  rdata_d = d_out;
          3'b100:  rdata_d = {24'd0, d_out[7:0]};
          3'b101:  rdata_d = {16'd0, d_out[15:0]};
          default: rdata_d = 32'd0;
        endcase
        state_d = StResp;
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      we_q     <= 1'b0;
      funct3_q <= 3'd0;
      addr_q   <= '0;
      wdata_q  <= 32'd0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // All outputs are gated by reset so a reset edge never commits a write or
  // accepts a request, even when it lands mid-ISSUE.
  always_comb begin
    unique case (funct3_q[1:0])
      2'b00:   wdata_masked = {24'd0, wdata_q[7:0]};
      2'b01:   wdata_masked = {16'd0, wdata_q[15:0]};
      default: wdata_masked = wdata_q;
    endcase
    issue      = (state_q == StIssue) && !reset;
    req_ready  = (state_q == StIdle) && !reset;
    resp_valid = (state_q == StResp) && !reset;
    resp_rdata = resp_valid ? rdata_q : 32'd0;
    resp_err   = resp_valid && err_q;
    d_addr     = issue ? addr_q : '0;
    d_size     = issue ? funct3_q[1:0] : 2'd0;
    d_in       = issue ? wdata_masked : 32'd0;
    w_en       = issue && we_q;
  end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu with a byte-addressed synchronous-read ram model.
module tb_lsu;

  localparam int unsigned ADDR_W = 14;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_in;
  logic [1:0]        d_size;
  logic              w_en;
  logic [31:0]       d_out;

  int vecs = 0;
  int errs = 0;
  int wr_cnt = 0;

  always #5 clk = ~clk;

  lsu #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .d_addr     (d_addr),
    .d_in       (d_in),
    .d_size     (d_size),
    .w_en       (w_en),
    .d_out      (d_out)
  );

  // ram model: sized write on w_en, registered right-justified read.
  logic [7:0] mem [0:255];
  logic [7:0] a0, a1, a2, a3;
  always_comb begin
    a0 = d_addr[7:0];
    a1 = a0 + 8'd1;
    a2 = a0 + 8'd2;
    a3 = a0 + 8'd3;
  end
  always @(posedge clk) begin
    if (w_en) begin
      mem[a0] <= d_in[7:0];
      if (d_size != 2'd0) mem[a1] <= d_in[15:8];
      if (d_size == 2'd2) begin
        mem[a2] <= d_in[23:16];
        mem[a3] <= d_in[31:24];
      end
      wr_cnt <= wr_cnt + 1;
    end
    case (d_size)
      2'd0:    d_out <= {24'd0, mem[a0]};
      2'd1:    d_out <= {16'd0, mem[a1], mem[a0]};
      default: d_out <= {mem[a3], mem[a2], mem[a1], mem[a0]};
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a request, accept it, and follow it to its response. lat counts
  // cycles from the accept cycle to the response cycle.
  task automatic run(input string tag, input logic we, input logic [2:0] f3,
                     input logic [ADDR_W-1:0] addr, input logic [31:0] wdata,
                     input int lat, input logic [31:0] exp_data, input logic exp_err,
                     input int exp_wen);
    int n;
    int wen_seen;
    int wr0;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    wr0        = wr_cnt;
    chk({tag, " ready"}, {31'd0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
    n = 1;
    wen_seen = 0;
    while (!resp_valid && n < 8) begin
      if (w_en) wen_seen++;
      tick();
      n++;
    end
    chk({tag, " latency"}, n, lat);
    chk({tag, " rdata"}, resp_rdata, exp_data);
    chk({tag, " err"}, {31'd0, resp_err}, {31'd0, exp_err});
    chk({tag, " w_en cycles"}, wen_seen, exp_wen);
    tick();
    chk({tag, " resp one cycle"}, {31'd0, resp_valid}, 32'd0);
    chk({tag, " writes"}, wr_cnt - wr0, exp_wen);
  endtask

  initial begin
    int n;
    int wr0;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = '0;
    req_wdata  = 32'd0;

    // Reset held two cycles.
    tick();
    tick();
    chk("rst req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst resp_rdata", resp_rdata, 32'd0);
    chk("rst resp_err", {31'd0, resp_err}, 32'd0);
    chk("rst d_addr", {18'd0, d_addr}, 32'd0);
    chk("rst d_in", d_in, 32'd0);
    chk("rst d_size", {30'd0, d_size}, 32'd0);
    chk("rst w_en", {31'd0, w_en}, 32'd0);
    reset = 1'b0;
    #1;
    chk("post-rst req_ready", {31'd0, req_ready}, 32'd1);

    // SW with ISSUE-cycle port check.
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 14'h0010; req_wdata = 32'hDEADBEEF;
    tick();
    req_valid = 1'b0;
    chk("sw w_en", {31'd0, w_en}, 32'd1);
    chk("sw d_size", {30'd0, d_size}, 32'd2);
    chk("sw d_addr", {18'd0, d_addr}, 32'h10);
    chk("sw d_in", d_in, 32'hDEADBEEF);
    chk("sw ready low", {31'd0, req_ready}, 32'd0);
    tick();
    chk("sw resp_valid", {31'd0, resp_valid}, 32'd1);
    chk("sw resp_err", {31'd0, resp_err}, 32'd0);
    chk("sw w_en off", {31'd0, w_en}, 32'd0);
    tick();

    run("lw", 1'b0, 3'b010, 14'h0010, 32'd0, 3, 32'hDEADBEEF, 1'b0, 0);

    // SB masks d_in to a byte.
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
    req_addr = 14'h0004; req_wdata = 32'h12345680;
    tick();
    req_valid = 1'b0;
    chk("sb d_in", d_in, 32'h00000080);
    chk("sb d_size", {30'd0, d_size}, 32'd0);
    tick();
    chk("sb resp", {31'd0, resp_valid}, 32'd1);
    tick();

    run("lb",  1'b0, 3'b000, 14'h0004, 32'd0, 3, 32'hFFFFFF80, 1'b0, 0);
    run("lbu", 1'b0, 3'b100, 14'h0004, 32'd0, 3, 32'h00000080, 1'b0, 0);
    run("sh",  1'b1, 3'b001, 14'h0008, 32'h0000FFFE, 2, 32'd0, 1'b0, 1);
    run("lh",  1'b0, 3'b001, 14'h0008, 32'd0, 3, 32'hFFFFFFFE, 1'b0, 0);
    run("lhu", 1'b0, 3'b101, 14'h0008, 32'd0, 3, 32'h0000FFFE, 1'b0, 0);

    // Errors: misaligned and illegal funct3.
    run("lw mis",  1'b0, 3'b010, 14'h0002, 32'd0, 1, 32'd0, 1'b1, 0);
    run("sh mis",  1'b1, 3'b001, 14'h0003, 32'h1234, 1, 32'd0, 1'b1, 0);
    run("ld f011", 1'b0, 3'b011, 14'h0000, 32'd0, 1, 32'd0, 1'b1, 0);
    run("st f100", 1'b1, 3'b100, 14'h0000, 32'd0, 1, 32'd0, 1'b1, 0);

    // Back-pressure: SW held valid while a load is in flight.
    wr0 = wr_cnt;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010;
    req_addr = 14'h0010; req_wdata = 32'd0;
    tick();
    req_we = 1'b1; req_addr = 14'h0040; req_wdata = 32'h55667788;
    chk("bp ready issue", {31'd0, req_ready}, 32'd0);
    tick();
    chk("bp ready wait", {31'd0, req_ready}, 32'd0);
    chk("bp no write in wait", {31'd0, w_en}, 32'd0);
    tick();
    chk("bp load resp", {31'd0, resp_valid}, 32'd1);
    chk("bp load data", resp_rdata, 32'hDEADBEEF);
    chk("bp ready resp", {31'd0, req_ready}, 32'd0);
    tick();
    chk("bp ready idle", {31'd0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
    chk("bp sw issue", {31'd0, w_en}, 32'd1);
    chk("bp sw d_in", d_in, 32'h55667788);
    tick();
    chk("bp sw resp", {31'd0, resp_valid}, 32'd1);
    tick();
    chk("bp one write", wr_cnt - wr0, 32'd1);
    run("bp readback", 1'b0, 3'b010, 14'h0040, 32'd0, 3, 32'h55667788, 1'b0, 0);

    // Reset landing in ISSUE of a store.
    run("pre sw20", 1'b1, 3'b010, 14'h0020, 32'h11112222, 2, 32'd0, 1'b0, 1);
    wr0 = wr_cnt;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 14'h0020; req_wdata = 32'hAAAAAAAA;
    tick();
    req_valid = 1'b0;
    chk("rsti w_en before", {31'd0, w_en}, 32'd1);
    reset = 1'b1;
    #1;
    chk("rsti w_en gated", {31'd0, w_en}, 32'd0);
    tick();
    reset = 1'b0;
    #1;
    chk("rsti idle", {31'd0, req_ready}, 32'd1);
    chk("rsti no resp", {31'd0, resp_valid}, 32'd0);
    n = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (resp_valid) n++;
    end
    chk("rsti resp dropped", n, 32'd0);
    chk("rsti no write", wr_cnt - wr0, 32'd0);
    run("rsti readback", 1'b0, 3'b010, 14'h0020, 32'd0, 3, 32'h11112222, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
